// File: rtl/fifo_reader_if.sv
// Bundles the FIFO-side and downstream-side signals of fifo_reader.
// master: the environment (FIFO + downstream consumer); slave: the reader itself.
// Clock and reset stay plain ports on the modules.
interface fifo_reader_if #(
    parameter int SIZE = 2
) ();
    logic            fifo_empty;
    logic [SIZE-1:0] fifo_item;
    logic            fifo_read;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_item;
    logic            flush;
    logic            flush_busy;

    modport master (
        output fifo_empty, fifo_item, out_ready, flush,
        input  fifo_read, out_valid, out_item, flush_busy
    );

    modport slave (
        input  fifo_empty, fifo_item, out_ready, flush,
        output fifo_read, out_valid, out_item, flush_busy
    );
endinterface

// File: rtl/fifo_reader.sv
// Purpose: pops a show-ahead FIFO into a 2-entry skid buffer feeding a valid/ready channel; flush drains and discards everything.
// Latency: an item popped in cycle N is presented on out_item/out_valid in cycle N+1; one item per cycle sustained.
// Backpressure: out_ready=0 fills the buffer to 2 entries, then fifo_read drops; FIFO_READER_STATS_EN adds deliv/drop counters.
module fifo_reader #(
    parameter int SIZE     = 2,
    parameter int ROUTERID = -1
) (
    input  logic clk,
    input  logic reset,
    fifo_reader_if.slave bus
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0] deliv_count,
    output logic [15:0] drop_count
`endif
);

    if (SIZE < 1 || ROUTERID < -1) begin : g_param_check
        $error("fifo_reader: SIZE must be >= 1 and ROUTERID >= -1");
    end

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state;
    logic [1:0]      occ;
    logic [SIZE-1:0] buf0;
    logic [SIZE-1:0] buf1;
    logic            read;
    logic            deq;
    logic            push;

    // Pop decision uses only registered state and the empty flag, never out_ready or flush.
    always_comb begin
        read = 1'b0;
        if (!reset) begin
            if (state == FLUSH) begin
                read = !bus.fifo_empty;
            end else begin
                read = !bus.fifo_empty && (occ != 2'd2);
            end
        end
    end

    assign deq  = (occ != 2'd0) && bus.out_ready;
    assign push = (state == RUN) && read && !bus.flush;

    assign bus.fifo_read  = read;
    assign bus.out_valid  = (occ != 2'd0);
    assign bus.out_item   = buf0;
    assign bus.flush_busy = (state == FLUSH);

    // Run/flush state machine together with the skid buffer; flushing empties the buffer so out_valid falls with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            occ   <= 2'd0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.flush) begin
                        state <= FLUSH;
                        occ   <= 2'd0;
                    end else begin
                        case ({push, deq})
                            2'b10: begin
                                if (occ == 2'd0) buf0 <= bus.fifo_item;
                                else             buf1 <= bus.fifo_item;
                                occ <= occ + 2'd1;
                            end
                            2'b01: begin
                                buf0 <= buf1;
                                occ  <= occ - 2'd1;
                            end
                            2'b11: begin
                                if (occ == 2'd1) begin
                                    buf0 <= bus.fifo_item;
                                end else begin
                                    buf0 <= buf1;
                                    buf1 <= bus.fifo_item;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                FLUSH: begin
                    if (bus.fifo_empty && !bus.flush) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [1:0]  drop_n;
    logic [16:0] drop_sum;

    // Items discarded this cycle: buffered entries not delivered plus the pop taken on the flush cycle.
    always_comb begin
        drop_n = 2'd0;
        if (state == RUN && bus.flush) begin
            drop_n = occ - {1'b0, deq} + {1'b0, read};
        end else if (state == FLUSH) begin
            drop_n = {1'b0, read};
        end
    end

    assign drop_sum = {1'b0, drop_count} + {15'd0, drop_n};

    // Saturating delivery and drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            deliv_count <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            if (deq && deliv_count != 16'hFFFF) deliv_count <= deliv_count + 16'd1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: directed vector table, hand-written sequences and random traffic.
// A queue-based FIFO model feeds the DUT and a queue-based reference predicts every cycle.
module tb_fifo_reader;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_reader_if #(.SIZE(W)) bus ();

`ifdef FIFO_READER_STATS_EN
    logic [15:0] deliv_count;
    logic [15:0] drop_count;
    fifo_reader #(.SIZE(W), .ROUTERID(3)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .deliv_count(deliv_count), .drop_count(drop_count)
    );
`else
    fifo_reader #(.SIZE(W), .ROUTERID(3)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] fq[$];     // FIFO contents, head at index 0
    logic [W-1:0] infl[$];   // reference: items popped but not yet delivered/discarded
    logic         m_flush = 1'b0;
    int           m_deliv = 0;
    int           m_drop = 0;

    logic         s_read, s_valid, s_busy;
    logic [W-1:0] s_item;

    typedef struct {
        logic r, f, rdy;
        int nld;
        logic [39:0] ld;
        logic e_read, e_valid, e_busy, chk_item;
        logic [W-1:0] e_item;
        int e_drop;
    } vec_t;
    vec_t vecs[$];
    logic [39:0] ld_tmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic f, input logic rdy, input int nld,
                                input logic [39:0] ld, input logic er, input logic ev,
                                input logic eb, input logic ci, input logic [W-1:0] ei,
                                input int ed);
        vec_t v;
        v.r = r; v.f = f; v.rdy = rdy; v.nld = nld; v.ld = ld;
        v.e_read = er; v.e_valid = ev; v.e_busy = eb; v.chk_item = ci; v.e_item = ei;
        v.e_drop = ed;
        vecs.push_back(v);
    endfunction

    // One clock cycle: drive inputs, check against the reference at the falling edge, advance at the rising edge.
    task automatic cycle(input logic r, input logic f, input logic rdy);
        logic empty, e_read, e_valid, deq;
        logic [W-1:0] head;
        int drops;
        reset = r;
        bus.flush = f;
        bus.out_ready = rdy;
        empty = (fq.size() == 0);
        head = empty ? '0 : fq[0];
        bus.fifo_empty = empty;
        bus.fifo_item = head;
        @(negedge clk);
        s_read = bus.fifo_read;
        s_valid = bus.out_valid;
        s_item = bus.out_item;
        s_busy = bus.flush_busy;
        e_read = r ? 1'b0 : (m_flush ? !empty : (!empty && infl.size() < 2));
        e_valid = !m_flush && infl.size() != 0;
        chk("model_read", 32'(s_read), 32'(e_read));
        chk("model_valid", 32'(s_valid), 32'(e_valid));
        chk("model_busy", 32'(s_busy), 32'(m_flush));
        if (e_valid) chk("model_item", 32'(s_item), 32'(infl[0]));
`ifdef FIFO_READER_STATS_EN
        chk("model_deliv", 32'(deliv_count), 32'(m_deliv));
        chk("model_drop", 32'(drop_count), 32'(m_drop));
`endif
        @(posedge clk);
        drops = 0;
        if (r) begin
            infl.delete();
            m_flush = 1'b0;
            m_deliv = 0;
            m_drop = 0;
        end else if (!m_flush) begin
            deq = (infl.size() != 0) && rdy;
            if (deq && m_deliv < 65535) m_deliv++;
            if (f) begin
                drops = infl.size() - int'(deq) + int'(e_read);
                infl.delete();
                m_flush = 1'b1;
            end else begin
                if (deq) void'(infl.pop_front());
                if (e_read) infl.push_back(head);
            end
        end else begin
            drops = int'(e_read);
            if (empty && !f) m_flush = 1'b0;
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        if (s_read && !empty) void'(fq.pop_front());
        #1;
    endtask

    logic [W-1:0] sent[$];
    logic [W-1:0] got[$];
    int inflight;
    int hold;
    logic rr, rf, rrdy;

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_item = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_item", 32'(bus.out_item), 32'd0);
        chk("reset_busy", 32'(bus.flush_busy), 32'd0);
`ifdef FIFO_READER_STATS_EN
        chk("reset_deliv", 32'(deliv_count), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
`endif
        @(posedge clk);
        #1;

        // r f rdy nld ld  read valid busy chk_item item drop
        // Stream 1,2,3,0 at full rate; reset cycle must not pop.
        add(1,0,1, 4,40'h00_00_03_02_01, 0,0,0, 0,8'h00,-1);
        add(0,0,1, 0,40'h0,              1,0,0, 0,8'h00,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h01,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h02,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h03,-1);
        add(0,0,1, 0,40'h0,              0,1,0, 1,8'h00,-1);
        add(0,0,1, 0,40'h0,              0,0,0, 0,8'h00,-1);
        // Back-pressure with five queued: two pops, then stable head, then the rest in order.
        add(0,0,0, 5,40'h0E_0D_0C_0B_0A, 1,0,0, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              1,1,0, 1,8'h0A,-1);
        add(0,0,0, 0,40'h0,              0,1,0, 1,8'h0A,-1);
        add(0,0,0, 0,40'h0,              0,1,0, 1,8'h0A,-1);
        add(0,0,1, 0,40'h0,              0,1,0, 1,8'h0A,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h0B,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h0C,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h0D,-1);
        add(0,0,1, 0,40'h0,              0,1,0, 1,8'h0E,-1);
        add(0,0,1, 0,40'h0,              0,0,0, 0,8'h00,-1);
        // Flush pulse at occ=2 with three still in the FIFO: five items discarded.
        add(1,0,0, 5,40'h24_23_22_21_20, 0,0,0, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              1,0,0, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              1,1,0, 1,8'h20,-1);
        add(0,1,0, 0,40'h0,              0,1,0, 1,8'h20,-1);
        add(0,0,0, 0,40'h0,              1,0,1, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              1,0,1, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              1,0,1, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              0,0,1, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              0,0,0, 0,8'h00, 5);
        // Flush held ten cycles on an empty FIFO.
        add(0,1,1, 0,40'h0,              0,0,0, 0,8'h00,-1);
        for (int i = 0; i < 9; i++) add(0,1,1, 0,40'h0, 0,0,1, 0,8'h00,-1);
        add(0,0,1, 0,40'h0,              0,0,1, 0,8'h00,-1);
        add(0,0,1, 0,40'h0,              0,0,0, 0,8'h00,-1);
        // Reset at occ=2 mid-stream, then streaming resumes.
        add(0,0,0, 5,40'h34_33_32_31_30, 1,0,0, 0,8'h00,-1);
        add(0,0,0, 0,40'h0,              1,1,0, 1,8'h30,-1);
        add(1,0,0, 0,40'h0,              0,1,0, 1,8'h30,-1);
        add(0,0,1, 0,40'h0,              1,0,0, 1,8'h00,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h32,-1);
        add(0,0,1, 0,40'h0,              1,1,0, 1,8'h33,-1);
        add(0,0,1, 0,40'h0,              0,1,0, 1,8'h34,-1);
        add(0,0,1, 0,40'h0,              0,0,0, 0,8'h00,-1);

        foreach (vecs[k]) begin
            ld_tmp = vecs[k].ld;
            for (int i = 0; i < vecs[k].nld; i++) fq.push_back(ld_tmp[8*i +: 8]);
            cycle(vecs[k].r, vecs[k].f, vecs[k].rdy);
            chk($sformatf("vec%0d_read", k), 32'(s_read), 32'(vecs[k].e_read));
            chk($sformatf("vec%0d_valid", k), 32'(s_valid), 32'(vecs[k].e_valid));
            chk($sformatf("vec%0d_busy", k), 32'(s_busy), 32'(vecs[k].e_busy));
            if (vecs[k].chk_item) chk($sformatf("vec%0d_item", k), 32'(s_item), 32'(vecs[k].e_item));
`ifdef FIFO_READER_STATS_EN
            if (vecs[k].e_drop >= 0) chk($sformatf("vec%0d_drop", k), 32'(drop_count), 32'(vecs[k].e_drop));
`endif
        end

        // Alternating out_ready with eight queued: exact order, at most two in flight.
        for (int i = 0; i < 8; i++) begin
            sent.push_back(W'(8'h40 + i));
            fq.push_back(W'(8'h40 + i));
        end
        inflight = 0;
        for (int c = 0; c < 30; c++) begin
            rrdy = (c % 2 == 0);
            cycle(1'b0, 1'b0, rrdy);
            if (s_valid && rrdy) begin
                got.push_back(s_item);
                inflight--;
            end
            if (s_read) inflight++;
            if (inflight > 2) chk("alt_inflight_max", 32'(inflight), 32'd2);
        end
        chk("alt_count", 32'(got.size()), 32'(sent.size()));
        foreach (sent[i]) begin
            if (i < got.size()) chk($sformatf("alt_item%0d", i), 32'(got[i]), 32'(sent[i]));
        end

        // Random traffic against the reference.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 6) fq.push_back(W'($urandom));
            rrdy = ($urandom_range(0, 3) != 0);
            if (hold > 0) begin
                hold--;
                rf = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                hold = $urandom_range(0, 4);
                rf = 1'b1;
            end else begin
                rf = 1'b0;
            end
            rr = ($urandom_range(0, 299) == 0);
            cycle(rr, rf, rrdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
